// File: rtl/bus_src_select.sv
// rtl/bus_src_select.sv - registered, strobe-captured source select for the internal bus
module bus_src_select #(
  parameter int              WIDTH    = 16,
  parameter int              NSRC     = 11,
  parameter int              SELW     = 4,
  parameter logic [NSRC-1:0] SRC_MASK = 11'b110_1111_1111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_valid,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic                  track,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  output logic [SELW-1:0]       cur_sel,
  output logic                  sel_err,
  output logic [7:0]            err_cnt
);

  localparam int NCODE = 1 << SELW;

  // Every encodable code maps to a legal bit; codes past NSRC are never legal.
  logic [NCODE-1:0] legal_map;

  genvar c;
  generate
    for (c = 0; c < NCODE; c++) begin : g_map
      if (c < NSRC) begin : g_slot
        assign legal_map[c] = SRC_MASK[c];
      end else begin : g_none
        assign legal_map[c] = 1'b0;
      end
    end
  endgenerate

  logic             bound;
  logic             sel_legal;
  logic             sel_illegal;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] cur_word;

  assign sel_legal   = sel_valid & legal_map[sel];
  assign sel_illegal = sel_valid & ~legal_map[sel];

  // Slot muxes for the incoming code and for the currently bound code.
  always_comb begin
    sel_word = '0;
    cur_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i))
        sel_word = src_bus[i*WIDTH +: WIDTH];
      if (cur_sel == SELW'(i))
        cur_word = src_bus[i*WIDTH +: WIDTH];
    end
  end

  // Bus register: a new legal select beats a track refresh; illegal selects freeze it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      cur_sel   <= '0;
      bound     <= 1'b0;
    end else begin
      out_valid <= sel_legal;
      if (sel_legal) begin
        data_out <= sel_word;
        cur_sel  <= sel;
        bound    <= 1'b1;
      end else if (!sel_valid && track && bound) begin
        data_out <= cur_word;
      end
    end
  end

  // Error log: an illegal select on the same edge as err_clr restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= 8'd0;
    end else if (sel_illegal) begin
      sel_err <= 1'b1;
      if (err_clr)
        err_cnt <= 8'd1;
      else if (err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
      err_cnt <= 8'd0;
    end
  end

endmodule
